// File: rtl/atm_pkg.sv
// Shared definitions for the register-file access sequencer: state encoding,
// register-file geometry and operation codes.
package atm_pkg;

  localparam int RF_AW = 4;
  localparam int RF_DW = 4;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: picks the next winner from the pending requests and keeps
// the rr_last history used to break ties.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [1:0] req,
  input  logic       take,
  input  logic       prio_mode,
  output logic [1:0] gnt_next
);

  logic rr_last_q;
  logic rr_last_d;

  always_comb begin
    gnt_next  = '0;
    rr_last_d = rr_last_q;
    case (req)
      2'b01: gnt_next = 2'b01;
      2'b10: gnt_next = 2'b10;
      2'b11: begin
        // History only moves on a contested grant, even in fixed-priority mode.
        if (prio_mode) gnt_next = 2'b01;
        else           gnt_next = rr_last_q ? 2'b01 : 2'b10;
        if (take) rr_last_d = gnt_next[1];
      end
      default: gnt_next = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) rr_last_q <= 1'b1;
    else     rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Shares a single-read/single-write register file between the keypad unit
// (requester 0) and the transaction unit (requester 1) with req/gnt/ack.
module regfile_access_ctrl
  import atm_pkg::*;
#(
  parameter int AW        = RF_AW,
  parameter int DW        = RF_DW,
  parameter int PRIO_MODE = 0
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          REQ0,
  input  logic          WE0,
  input  logic [AW-1:0] ADDR0,
  input  logic [DW-1:0] WDATA0,
  output logic          GNT0,
  output logic          ACK0,
  input  logic          REQ1,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA1,
  output logic          GNT1,
  output logic          ACK1,
  output logic [DW-1:0] RDATA,
  output logic          BUSY,
  output logic [AW-1:0] RF_RA,
  output logic [AW-1:0] RF_WA,
  output logic          RF_WR,
  output logic [DW-1:0] RF_LD_DATA,
  input  logic [DW-1:0] RF_DATA,
  output logic          RF_CLRN
);

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    gnt_next;
  logic          take;

  assign take = (state_q == ST_IDLE) && (REQ0 || REQ1);

  rr_arbiter2 u_arb (
    .CLK      (CLK),
    .CLR      (CLR),
    .req      ({REQ1, REQ0}),
    .take     (take),
    .prio_mode(PRIO_MODE != 0),
    .gnt_next (gnt_next)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          sel_d   = gnt_next[1];
          op_d    = gnt_next[1] ? WE1    : WE0;
          addr_d  = gnt_next[1] ? ADDR1  : ADDR0;
          wdata_d = gnt_next[1] ? WDATA1 : WDATA0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (op_q == OP_READ) rdata_d = RF_DATA;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Everything below is decoded from registers, so CLR zeroes it at once.
  assign GNT0       = (state_q == ST_ACCESS) && !sel_q;
  assign GNT1       = (state_q == ST_ACCESS) &&  sel_q;
  assign ACK0       = (state_q == ST_RESP)   && !sel_q;
  assign ACK1       = (state_q == ST_RESP)   &&  sel_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign RDATA      = rdata_q;
  assign RF_RA      = addr_q;
  assign RF_WA      = addr_q;
  assign RF_LD_DATA = wdata_q;
  assign RF_WR      = (state_q == ST_ACCESS) && (op_q == OP_WRITE);
  assign RF_CLRN    = ~CLR;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: two instances (round-robin and fixed priority)
// share stimulus, each with its own register-file stub and transaction-level model.
module tb_regfile_access_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [3:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;

  logic [1:0] gnt0_v, gnt1_v, ack0_v, ack1_v, busy_v, rf_wr_v, rf_clrn_v;
  logic [3:0] rdata_v [2];
  logic [3:0] rf_ra_v [2];
  logic [3:0] rf_wa_v [2];
  logic [3:0] rf_ld_v [2];
  logic [3:0] rf_data0, rf_data1;
  logic [3:0] mem0 [16];
  logic [3:0] mem1 [16];

  regfile_access_ctrl #(.AW(4), .DW(4), .PRIO_MODE(0)) u_rr (
    .CLK(clk), .CLR(clr),
    .REQ0(req0), .WE0(we0), .ADDR0(addr0), .WDATA0(wdata0), .GNT0(gnt0_v[0]), .ACK0(ack0_v[0]),
    .REQ1(req1), .WE1(we1), .ADDR1(addr1), .WDATA1(wdata1), .GNT1(gnt1_v[0]), .ACK1(ack1_v[0]),
    .RDATA(rdata_v[0]), .BUSY(busy_v[0]), .RF_RA(rf_ra_v[0]), .RF_WA(rf_wa_v[0]),
    .RF_WR(rf_wr_v[0]), .RF_LD_DATA(rf_ld_v[0]), .RF_DATA(rf_data0), .RF_CLRN(rf_clrn_v[0])
  );

  regfile_access_ctrl #(.AW(4), .DW(4), .PRIO_MODE(1)) u_fp (
    .CLK(clk), .CLR(clr),
    .REQ0(req0), .WE0(we0), .ADDR0(addr0), .WDATA0(wdata0), .GNT0(gnt0_v[1]), .ACK0(ack0_v[1]),
    .REQ1(req1), .WE1(we1), .ADDR1(addr1), .WDATA1(wdata1), .GNT1(gnt1_v[1]), .ACK1(ack1_v[1]),
    .RDATA(rdata_v[1]), .BUSY(busy_v[1]), .RF_RA(rf_ra_v[1]), .RF_WA(rf_wa_v[1]),
    .RF_WR(rf_wr_v[1]), .RF_LD_DATA(rf_ld_v[1]), .RF_DATA(rf_data1), .RF_CLRN(rf_clrn_v[1])
  );

  // Register-file stubs: combinational read, clocked write, async clear.
  assign rf_data0 = mem0[rf_ra_v[0]];
  assign rf_data1 = mem1[rf_ra_v[1]];

  always @(posedge clk or negedge rf_clrn_v[0])
    if (!rf_clrn_v[0]) for (int i = 0; i < 16; i++) mem0[i] <= '0;
    else if (rf_wr_v[0]) mem0[rf_wa_v[0]] <= rf_ld_v[0];

  always @(posedge clk or negedge rf_clrn_v[1])
    if (!rf_clrn_v[1]) for (int i = 0; i < 16; i++) mem1[i] <= '0;
    else if (rf_wr_v[1]) mem1[rf_wa_v[1]] <= rf_ld_v[1];

  // Transaction-level reference: phase 0 waiting, 1 granted, 2 acknowledged.
  int ph [2], who [2], ma [2], md [2], rd [2], rrl [2];
  bit wr [2];
  int mm [2][16];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ph[m] = 0; rd[m] = 0; rrl[m] = 1; who[m] = 0; wr[m] = 0; ma[m] = 0; md[m] = 0;
      for (int i = 0; i < 16; i++) mm[m][i] = 0;
    end
  endtask

  task automatic model_step();
    if (clr) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (ph[m] == 0) begin
        if (req0 || req1) begin
          int w;
          if (req0 && req1) begin
            w = (m == 1) ? 0 : (rrl[m] == 0 ? 1 : 0);
            rrl[m] = w;
          end else begin
            w = req0 ? 0 : 1;
          end
          who[m] = w;
          wr[m]  = (w == 1) ? we1 : we0;
          ma[m]  = (w == 1) ? int'(addr1) : int'(addr0);
          md[m]  = (w == 1) ? int'(wdata1) : int'(wdata0);
          ph[m]  = 1;
        end
      end else if (ph[m] == 1) begin
        if (wr[m]) mm[m][ma[m]] = md[m];
        else       rd[m] = mm[m][ma[m]];
        ph[m] = 2;
      end else begin
        ph[m] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d gnt0", m),  32'(gnt0_v[m]),  32'(ph[m] == 1 && who[m] == 0));
      chk($sformatf("m%0d gnt1", m),  32'(gnt1_v[m]),  32'(ph[m] == 1 && who[m] == 1));
      chk($sformatf("m%0d ack0", m),  32'(ack0_v[m]),  32'(ph[m] == 2 && who[m] == 0));
      chk($sformatf("m%0d ack1", m),  32'(ack1_v[m]),  32'(ph[m] == 2 && who[m] == 1));
      chk($sformatf("m%0d busy", m),  32'(busy_v[m]),  32'(ph[m] != 0));
      chk($sformatf("m%0d rdata", m), 32'(rdata_v[m]), 32'(rd[m]));
      chk($sformatf("m%0d rf_wr", m), 32'(rf_wr_v[m]), 32'(ph[m] == 1 && wr[m]));
      chk($sformatf("m%0d rf_clrn", m), 32'(rf_clrn_v[m]), 32'(!clr));
      if (ph[m] == 1) begin
        chk($sformatf("m%0d rf_ra", m), 32'(rf_ra_v[m]), 32'(ma[m]));
        chk($sformatf("m%0d rf_wa", m), 32'(rf_wa_v[m]), 32'(ma[m]));
        chk($sformatf("m%0d rf_ld", m), 32'(rf_ld_v[m]), 32'(md[m]));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s m%0d outs", tag, m),
          32'({gnt0_v[m], gnt1_v[m], ack0_v[m], ack1_v[m], busy_v[m], rf_wr_v[m], rf_clrn_v[m]}), 32'd0);
      chk($sformatf("%s m%0d buses", tag, m),
          32'({rdata_v[m], rf_ra_v[m], rf_wa_v[m], rf_ld_v[m]}), 32'd0);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // One complete single-requester access; ack and read data checked at the ACK cycle.
  task automatic do_txn(input int w, input bit we, input int a, input int d, input int exp_rd);
    if (w == 0) begin req0 = 1; we0 = we; addr0 = 4'(a); wdata0 = 4'(d); req1 = 0; end
    else        begin req1 = 1; we1 = we; addr1 = 4'(a); wdata1 = 4'(d); req0 = 0; end
    tick();
    req0 = 0; req1 = 0;
    tick();
    chk($sformatf("txn ack r%0d a%0d", w, a), 32'(w == 0 ? ack0_v[0] : ack1_v[0]), 32'd1);
    if (!we) chk($sformatf("txn rdata a%0d", a), 32'(rdata_v[0]), 32'(exp_rd));
    tick();
  endtask

  typedef struct {
    int who;
    bit we;
    int addr;
    int data;
    int exp_rdata;
  } vec_t;

  vec_t vt [6];
  int   rr_seq [$];
  int   fp_seq [$];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{who: 0, we: 1, addr: 5,  data: 'hA, exp_rdata: 0};
    vt[1] = '{who: 0, we: 0, addr: 5,  data: 0,   exp_rdata: 'hA};
    vt[2] = '{who: 1, we: 1, addr: 12, data: 'h3, exp_rdata: 0};
    vt[3] = '{who: 0, we: 1, addr: 13, data: 'hC, exp_rdata: 0};
    vt[4] = '{who: 1, we: 0, addr: 12, data: 0,   exp_rdata: 'h3};
    vt[5] = '{who: 0, we: 0, addr: 13, data: 0,   exp_rdata: 'hC};

    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_all_zero("reset");
    clr = 0;
    tick();

    foreach (vt[i]) do_txn(vt[i].who, vt[i].we, vt[i].addr, vt[i].data, vt[i].exp_rdata);

    for (int unsigned a = 0; a < 16; a++) do_txn(int'(a % 2), 1'b1, int'(a), int'(a), 0);
    for (int unsigned a = 0; a < 16; a++) do_txn(int'((a + 1) % 2), 1'b0, int'(a), 0, int'(a));

    // Both requesters held high.
    clr = 1; tick(); clr = 0; tick();
    req0 = 1; we0 = 0; addr0 = 4'd2;
    req1 = 1; we1 = 0; addr1 = 4'd9;
    for (int unsigned c = 0; c < 12; c++) begin
      tick();
      if (gnt0_v[0]) rr_seq.push_back(0);
      if (gnt1_v[0]) rr_seq.push_back(1);
      if (gnt0_v[1]) fp_seq.push_back(0);
      if (gnt1_v[1]) fp_seq.push_back(1);
    end
    chk("rr grant count", 32'(rr_seq.size()), 32'd4);
    chk("fp grant count", 32'(fp_seq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr grant %0d", i), 32'(i < rr_seq.size() ? rr_seq[i] : -1), 32'(i % 2));
      chk($sformatf("fp grant %0d", i), 32'(i < fp_seq.size() ? fp_seq[i] : -1), 32'd0);
    end
    req0 = 0;
    begin
      int n = 0;
      bit got = 0;
      while (!got && n < 6) begin
        tick();
        n++;
        if (gnt1_v[1]) got = 1;
      end
      chk("fp starve release cycles", 32'(got ? n : 99), 32'd1);
    end
    req1 = 0;
    repeat (3) tick();

    // CLR pulse during the ACCESS cycle of a write.
    req0 = 1; we0 = 1; addr0 = 4'd7; wdata0 = 4'hF;
    tick();
    req0 = 0;
    chk("abort rf_wr before clr", 32'(rf_wr_v[0]), 32'd1);
    #2 clr = 1;
    #1;
    chk_all_zero("abort");
    model_reset();
    tick();
    chk("abort no ack", 32'({ack0_v, ack1_v}), 32'd0);
    clr = 0;
    tick();
    do_txn(0, 1'b0, 7, 0, 0);
    do_txn(0, 1'b1, 7, 'hF, 0);
    do_txn(1, 1'b0, 7, 0, 'hF);

    // REQ0 arrives while requester 1 is being served.
    do_txn(0, 1'b1, 12, 'h9, 0);
    req1 = 1; we1 = 0; addr1 = 4'd12;
    tick();
    chk("cont gnt1", 32'(gnt1_v[0]), 32'd1);
    req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 4'h6;
    tick();
    chk("cont ack1", 32'(ack1_v[0]), 32'd1);
    chk("cont rdata", 32'(rdata_v[0]), 32'h9);
    chk("cont gnt0 held off", 32'(gnt0_v[0]), 32'd0);
    req1 = 0;
    tick();
    chk("cont idle gnt0", 32'(gnt0_v[0]), 32'd0);
    tick();
    chk("cont gnt0 late", 32'(gnt0_v[0]), 32'd1);
    req0 = 0;
    repeat (2) tick();

    // Random traffic with occasional reset pulses.
    for (int unsigned c = 0; c < 400; c++) begin
      req0   = ($urandom_range(0, 2) == 0);
      req1   = ($urandom_range(0, 2) == 0);
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      addr0  = 4'($urandom_range(0, 15));
      addr1  = 4'($urandom_range(0, 15));
      wdata0 = 4'($urandom_range(0, 15));
      wdata1 = 4'($urandom_range(0, 15));
      clr    = ($urandom_range(0, 79) == 0);
      tick();
    end
    clr = 0; req0 = 0; req1 = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
